// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// BITS_PER_CYCLE bits per iteration, fast path for divide-by-zero and signed overflow.
module muldiv_iter #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N);
   localparam int PW = XLEN + BITS_PER_CYCLE;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef struct packed {
      logic [2:0] f3;
      logic       neg_q;   // sign of product / quotient
      logic       neg_r;   // sign of remainder (follows dividend)
   } op_t;

   logic [1:0]        state;
   op_t               op;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   opnd;   // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc;    // {partial product, multiplier} or {remainder, quotient}

   logic              is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, fast;
   logic [XLEN-1:0]   mag_a, mag_b, fast_res;

   always_comb begin
      is_div   = funct3[2];
      a_sgn    = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
      b_sgn    = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
      a_neg    = a_sgn & opA[XLEN-1];
      b_neg    = b_sgn & opB[XLEN-1];
      mag_a    = a_neg ? -opA : opA;
      mag_b    = b_neg ? -opB : opB;
      div0     = is_div & (opB == '0);
      ovf      = is_div & ~funct3[0] & (opA == {1'b1, {(XLEN-1){1'b0}}}) & (&opB);
      fast     = div0 | ovf;
      if (div0) fast_res = funct3[1] ? opA : '1;
      else      fast_res = funct3[1] ? '0 : opA;
   end

   logic [PW-1:0]     pp, psum;
   logic [2*XLEN-1:0] mul_nxt, div_nxt;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   r, q;

   always_comb begin
      pp      = PW'(opnd) * PW'(acc[BITS_PER_CYCLE-1:0]);
      psum    = PW'(acc[2*XLEN-1:XLEN]) + pp;
      mul_nxt = {psum, acc[XLEN-1:BITS_PER_CYCLE]};
      r       = acc[2*XLEN-1:XLEN];
      q       = acc[XLEN-1:0];
      trial   = '0;
      // one restoring step per retired quotient bit
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         trial = {r, q[XLEN-1]};
         q     = {q[XLEN-2:0], 1'b0};
         if (trial >= {1'b0, opnd}) begin
            trial = trial - {1'b0, opnd};
            q[0]  = 1'b1;
         end
         r = trial[XLEN-1:0];
      end
      div_nxt = {r, q};
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   always_comb begin
      prod_s = op.neg_q ? -acc : acc;
      quo_s  = op.neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s  = op.neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op.f3)
         3'd0:                fix_res = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    fix_res = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:          fix_res = quo_s;
         default:             fix_res = rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         result <= '0;
         op     <= '0;
         cnt    <= '0;
         opnd   <= '0;
         acc    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op    <= '{f3: funct3, neg_q: a_neg ^ b_neg, neg_r: a_neg};
                  opnd  <= is_div ? mag_b : mag_a;
                  acc   <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                  cnt   <= CW'(N - 1);
                  if (fast) begin
                     result <= fast_res;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_CALC;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               acc <= op.f3[2] ? div_nxt : mul_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= S_FIX;
            end
            S_FIX: begin
               result <= fix_res;
               state  <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_CALC) | (state == S_FIX);
   assign done = (state == S_DONE);

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit; next-generation execute block for the core, alongside the single-cycle ALU.
- Accepts one M-extension operation per start pulse and returns the result after a fixed, parametrised number of cycles.
- Core stalls PC update and register write-back while busy is high, then writes result on done.
- Width and per-cycle radix are parametrised; the existing ALU has neither multi-cycle behaviour nor these operations.

Parameters:
- XLEN, 32, operand/result width; 8 ≤ XLEN ≤ 64, even.
- BITS_PER_CYCLE, 1, bits retired per iteration (1, 2 or 4); must divide XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when idle or done.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opA  input  XLEN  rs1 value (dividend / multiplicand).
- opB  input  XLEN  rs2 value (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  operation result; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, result=0. Reset aborts any in-flight op with no done pulse.
- N = XLEN/BITS_PER_CYCLE.
- States: IDLE, CALC, FIX, DONE.
- Operand capture:
  - IDLE or DONE with start=1: capture funct3, opA, opB. Convert signed operands to magnitudes and record result sign.
  - Next state is CALC, or DONE directly on the fast path.
- CALC:
  - Multiply: shift-add, BITS_PER_CYCLE multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring, BITS_PER_CYCLE quotient bits per cycle.
  - Iteration counter runs from N-1 down to 0; at 0 go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Select the result: low half (MUL), high half (MULH/HSU/HU), quotient (DIV/DIVU), or remainder (REM/REMU).
  - Load result, then go to DONE.
- DONE: done=1 for exactly one cycle.
  - If start=1, accept a new op (back-to-back).
  - Otherwise go to IDLE.
- busy: 1 in CALC and FIX, 0 in IDLE and DONE.
- Latency, with start accepted at edge k:
  - busy rises after edge k.
  - done high in the cycle after edge k+N+1, i.e. N+2 cycles after acceptance.
- start while busy=1 is ignored; captured operands do not change mid-operation.
- Signedness: MULHSU treats opA signed and opB unsigned. MULH, DIV and REM treat both signed. The U-variants treat both unsigned.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- Fast path: IDLE/DONE → DONE, with done one cycle after acceptance.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give opA.
  - Signed overflow (opA = most-negative, opB = -1): DIV gives opA; REM gives 0.
- result changes only when entering DONE. It is stable in all other states.
- Arithmetic is modulo 2^XLEN; there are no exceptions or flags.

Test Plan:
- Reset: assert rst_n=0 mid-CALC of a MUL, release. Required: busy=0, done=0, result=0; no done pulse for the aborted op.
- XLEN=32, BPC=1, MUL 0x0000_1234 × 0x0000_5678, start at cycle 0. Required: result 0x0626_0060, done at cycle 34, busy high for cycles 1–33.
- MULH 0xFFFF_FFFF × 0xFFFF_FFFF gives 0x0000_0000. MULHU on the same operands gives 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF × 0x0000_0002 gives 0xFFFF_FFFF.
- DIV -7/2 gives 0xFFFF_FFFD. REM -7/2 gives 0xFFFF_FFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- Boundaries, each with done at cycle 1:
  - DIV x/0 gives 0xFFFF_FFFF.
  - REMU 0x55/0 gives 0x55.
  - DIV 0x8000_0000/0xFFFF_FFFF gives 0x8000_0000.
  - REM on the same operands gives 0.
- Back-to-back: start held high through DONE with a new op. Required: the second op is accepted in the DONE cycle. A start pulse during busy is ignored (result unchanged). With BPC=4, latency is 10 cycles.
